multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
// - Sequencing controller for the multicycle MIPS datapath: one shared memory, one ALU, PC/IR/ALUOut registers.
// - Decodes opcode/funct from the IR and steps the datapath through fetch/decode/execute/memory/writeback.
// - Drives all datapath select/enable lines each cycle.
// - Stalls on a req/ready memory handshake.
// - Sits between the IR and the datapath; replaces the single-cycle control_unit in the multicycle build.
// PARAMETERS
// - FETCH_TIMEOUT  default 0  nonzero: pulse illegal and restart FETCH after this many un-acked cycles in a memory state; 0 = wait forever
// PORTS
// - clock       in   1  system clock, rising edge
// - reset       in   1  synchronous, active-high
// - opcode      in   6  IR[31:26]
// - funct       in   6  IR[5:0]
// - zero        in   1  ALU zero flag (current-cycle ALU result)
// - mem_ready   in   1  memory completes the current request this cycle
// - mem_req     out  1  memory access request (held until mem_ready)
// - iord        out  1  0 = address from PC, 1 = address from ALUOut
// - dmem_we     out  1  memory write (valid only with mem_req)
// - ir_we       out  1  load IR from memory read data
// - pc_we       out  1  load PC with the sel_pc source
// - rf_we       out  1  register file write
// - sel_wa      out  2  write address: 0 rt, 1 rd, 2 r31
// - sel_alu_a   out  1  ALU A: 0 PC, 1 rs
// - sel_alu_b   out  2  ALU B: 0 rt, 1 const 4, 2 signimm, 3 signimm<<2
// - sel_result  out  2  RF write data: 0 ALUOut, 1 mem data reg, 2 PC
// - sel_pc      out  2  PC source: 0 ALU result, 1 ALUOut, 2 jump target, 3 rs
// - alu_op      out  2  00 add, 01 sub, 10 decode funct
// - state       out  4  current state encoding (debug)
// - illegal     out  1  one-cycle pulse on unsupported opcode/funct or timeout
// BEHAVIOUR
// - Reset: state=FETCH next edge, including mid-instruction and mid-handshake.
//   - All strobes (mem_req, dmem_we, ir_we, pc_we, rf_we, illegal) are 0 during the reset cycle.
//   - All selects are 0 during the reset cycle.
// - Outputs are a Moore decode of state; the FETCH ir_we/pc_we and BRANCH pc_we are additionally qualified by mem_ready/zero.
// - FETCH: mem_req=1, iord=0, sel_alu_a=0, sel_alu_b=1, alu_op=00, sel_pc=0.
//   - ir_we=pc_we=mem_ready. Stay in FETCH until mem_ready=1, then go to DECODE.
// - DECODE: sel_alu_a=0, sel_alu_b=3, alu_op=00 (branch target into ALUOut). Next state by opcode:
//   - 0x23/0x2B -> MEMADR; 0x00 -> RTYPE_EX (funct 0x08 -> JR); 0x08 -> ADDI_EX
//   - 0x04 -> BRANCH; 0x02 -> JUMP; 0x03 -> JAL
//   - anything else -> FETCH with illegal=1
// - MEMADR: sel_alu_a=1, sel_alu_b=2, alu_op=00. Next: MEMRD if opcode 0x23, else MEMWR.
// - MEMRD: mem_req=1, iord=1; wait for mem_ready, then MEMWB.
// - MEMWB: rf_we=1, sel_wa=0, sel_result=1 -> FETCH.
// - MEMWR: mem_req=1, iord=1, dmem_we=1; wait for mem_ready -> FETCH. dmem_we drops together with mem_req.
// - RTYPE_EX: sel_alu_a=1, sel_alu_b=0, alu_op=10 -> ALU_WB.
// - ALU_WB: rf_we=1, sel_wa=1, sel_result=0 -> FETCH.
// - ADDI_EX: sel_alu_a=1, sel_alu_b=2, alu_op=00 -> ADDI_WB.
// - ADDI_WB: rf_we=1, sel_wa=0, sel_result=0 -> FETCH.
// - BRANCH: sel_alu_a=1, sel_alu_b=0, alu_op=01, sel_pc=1, pc_we=zero -> FETCH.
// - JUMP: pc_we=1, sel_pc=2 -> FETCH.
// - JAL: rf_we=1, sel_wa=2, sel_result=2, pc_we=1, sel_pc=2 -> FETCH. The RF captures the old PC (already PC+4) on the same edge.
// - JR: pc_we=1, sel_pc=3 -> FETCH.
// - Latencies (cycles, no wait states): lw 5, sw 4, R/addi 4, beq/j/jal/jr 3. Each mem_ready=0 cycle adds 1.
// - Timeout (FETCH_TIMEOUT>0): a counter clears on state entry and counts un-acked cycles in FETCH/MEMRD/MEMWR.
//   - When count==FETCH_TIMEOUT-1 and mem_ready=0: pulse illegal, drop mem_req, go to FETCH next.
//   - mem_ready=1 on the same cycle as the limit wins; no illegal pulse.
// CONFIGURATION
// - Macro MC_PERF_CNT_EN adds outputs perf_cycles[31:0] and perf_instrs[31:0]. Both clear on reset and wrap at 2^32.
//   - perf_cycles increments every non-reset cycle.
//   - perf_instrs increments on each FETCH->DECODE transition.
// - Macro undefined: those ports, and the counter logic, do not exist.
// STRUCTURE
// - Package mc_control_pkg: mc_state_t enum, opcode/funct localparams, and select-encoding localparams for sel_wa/alu_b/result/pc and alu_op.
// - Reuse control_signals for anything already defined there.
// - One sub-module, mc_output_decode: combinational state -> control-word decode.
//   - The top holds the state register, next-state logic, the timeout counter and the perf counters.
// TESTING
// - lw, opcode=0x23, mem_ready always 1 -> state sequence FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH. rf_we=1 only in MEMWB, with sel_wa=0 and sel_result=1.
// - sw 0x2B with mem_ready held 0 for 3 cycles in MEMWR -> mem_req=dmem_we=1 for 4 cycles. pc_we=0 throughout. Back to FETCH.
// - beq 0x04: zero=1 -> pc_we=1 and sel_pc=1 in BRANCH; zero=0 -> pc_we=0. Both take 3 cycles.
// - jal 0x03 -> JAL cycle shows rf_we=1, sel_wa=2, sel_result=2, pc_we=1, sel_pc=2. jr (0x00/0x08) -> sel_pc=3.
// - opcode=0x3F -> illegal=1 for exactly 1 cycle in DECODE, then FETCH. reset=1 during MEMRD -> next state FETCH, strobes 0.
// - FETCH_TIMEOUT=4 with mem_ready stuck 0 -> illegal pulse on the 4th FETCH cycle. Under MC_PERF_CNT_EN: 3 beq -> perf_instrs=3, perf_cycles=9.

Source files
------------

// File: rtl/mc_control_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// Optional MC_PERF_CNT_EN adds cycle and instruction counters to the top.
package mc_control_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    ALU_WB   = 4'd7,
    ADDI_EX  = 4'd8,
    ADDI_WB  = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    JAL      = 4'd12,
    JR       = 4'd13
  } mc_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [1:0] WA_RT  = 2'd0;
  localparam logic [1:0] WA_RD  = 2'd1;
  localparam logic [1:0] WA_R31 = 2'd2;

  localparam logic       ALUA_PC = 1'b0;
  localparam logic       ALUA_RS = 1'b1;

  localparam logic [1:0] ALUB_RT      = 2'd0;
  localparam logic [1:0] ALUB_FOUR    = 2'd1;
  localparam logic [1:0] ALUB_IMM     = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

  localparam logic [1:0] RES_ALUOUT  = 2'd0;
  localparam logic [1:0] RES_MEMDATA = 2'd1;
  localparam logic [1:0] RES_PC      = 2'd2;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       dmem_we;
    logic       ir_we;
    logic       pc_we;
    logic       rf_we;
    logic [1:0] sel_wa;
    logic       sel_alu_a;
    logic [1:0] sel_alu_b;
    logic [1:0] sel_result;
    logic [1:0] sel_pc;
    logic [1:0] alu_op;
  } mc_ctrl_t;

  function automatic logic is_mem_state(input mc_state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

  // R-type functs the datapath ALU can execute (jr is handled separately).
  function automatic logic rtype_funct_ok(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state -> control-word decode; only FETCH and BRANCH
// look at the mem_ready / zero inputs.
module mc_output_decode
  import mc_control_pkg::*;
(
  input  mc_state_t state,
  input  logic      mem_ready,
  input  logic      zero,
  output mc_ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.sel_alu_a = ALUA_PC;
        ctrl.sel_alu_b = ALUB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.sel_pc    = PC_ALU;
        ctrl.ir_we     = mem_ready;
        ctrl.pc_we     = mem_ready;
      end
      DECODE: begin
        ctrl.sel_alu_a = ALUA_PC;
        ctrl.sel_alu_b = ALUB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      MEMADR, ADDI_EX: begin
        ctrl.sel_alu_a = ALUA_RS;
        ctrl.sel_alu_b = ALUB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      MEMWB: begin
        ctrl.rf_we      = 1'b1;
        ctrl.sel_wa     = WA_RT;
        ctrl.sel_result = RES_MEMDATA;
      end
      MEMWR: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        ctrl.dmem_we = 1'b1;
      end
      RTYPE_EX: begin
        ctrl.sel_alu_a = ALUA_RS;
        ctrl.sel_alu_b = ALUB_RT;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ALU_WB: begin
        ctrl.rf_we      = 1'b1;
        ctrl.sel_wa     = WA_RD;
        ctrl.sel_result = RES_ALUOUT;
      end
      ADDI_WB: begin
        ctrl.rf_we      = 1'b1;
        ctrl.sel_wa     = WA_RT;
        ctrl.sel_result = RES_ALUOUT;
      end
      BRANCH: begin
        ctrl.sel_alu_a = ALUA_RS;
        ctrl.sel_alu_b = ALUB_RT;
        ctrl.alu_op    = ALU_SUB;
        ctrl.sel_pc    = PC_ALUOUT;
        ctrl.pc_we     = zero;
      end
      JUMP: begin
        ctrl.pc_we  = 1'b1;
        ctrl.sel_pc = PC_JUMP;
      end
      JAL: begin
        // PC already holds PC+4, so the link value is the current PC.
        ctrl.rf_we      = 1'b1;
        ctrl.sel_wa     = WA_R31;
        ctrl.sel_result = RES_PC;
        ctrl.pc_we      = 1'b1;
        ctrl.sel_pc     = PC_JUMP;
      end
      JR: begin
        ctrl.pc_we  = 1'b1;
        ctrl.sel_pc = PC_RS;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS sequencing controller: state register, next-state logic,
// memory timeout and (with MC_PERF_CNT_EN) performance counters.
module multicycle_control_fsm
  import mc_control_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic       rf_we,
  output logic [1:0] sel_wa,
  output logic       sel_alu_a,
  output logic [1:0] sel_alu_b,
  output logic [1:0] sel_result,
  output logic [1:0] sel_pc,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       illegal
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_instrs
`endif
);

  mc_state_t state_reg;
  mc_state_t state_next;
  mc_ctrl_t  ctrl;
  logic      illegal_decode;
  logic      timeout_hit;

  mc_output_decode u_decode (
    .state     (state_reg),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (ctrl)
  );

  always_comb begin
    state_next     = state_reg;
    illegal_decode = 1'b0;
    case (state_reg)
      FETCH:  if (mem_ready) state_next = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_ADDI:      state_next = ADDI_EX;
          OP_BEQ:       state_next = BRANCH;
          OP_J:         state_next = JUMP;
          OP_JAL:       state_next = JAL;
          OP_RTYPE: begin
            if (funct == FN_JR)             state_next = JR;
            else if (rtype_funct_ok(funct)) state_next = RTYPE_EX;
            else begin
              state_next     = FETCH;
              illegal_decode = 1'b1;
            end
          end
          default: begin
            state_next     = FETCH;
            illegal_decode = 1'b1;
          end
        endcase
      end
      MEMADR:   state_next = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    if (mem_ready) state_next = MEMWB;
      MEMWR:    if (mem_ready) state_next = FETCH;
      RTYPE_EX: state_next = ALU_WB;
      ADDI_EX:  state_next = ADDI_WB;
      default:  state_next = FETCH;
    endcase
    if (timeout_hit) state_next = FETCH;
  end

  always_ff @(posedge clock) begin
    if (reset) state_reg <= FETCH;
    else       state_reg <= state_next;
  end

  generate
    if (FETCH_TIMEOUT > 0) begin : g_timeout
      localparam int CW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
      logic [CW-1:0] wait_count_reg;

      // A same-cycle mem_ready takes priority over the limit.
      assign timeout_hit = is_mem_state(state_reg) && !mem_ready &&
                           (wait_count_reg == CW'(FETCH_TIMEOUT - 1));

      always_ff @(posedge clock) begin
        if (reset || timeout_hit || (state_next != state_reg))
          wait_count_reg <= '0;
        else if (is_mem_state(state_reg) && !mem_ready)
          wait_count_reg <= wait_count_reg + 1'b1;
      end
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // Everything is forced low while reset is asserted.
  assign mem_req    = !reset && ctrl.mem_req && !timeout_hit;
  assign dmem_we    = !reset && ctrl.dmem_we && !timeout_hit;
  assign iord       = !reset && ctrl.iord;
  assign ir_we      = !reset && ctrl.ir_we;
  assign pc_we      = !reset && ctrl.pc_we;
  assign rf_we      = !reset && ctrl.rf_we;
  assign sel_wa     = reset ? 2'd0 : ctrl.sel_wa;
  assign sel_alu_a  = !reset && ctrl.sel_alu_a;
  assign sel_alu_b  = reset ? 2'd0 : ctrl.sel_alu_b;
  assign sel_result = reset ? 2'd0 : ctrl.sel_result;
  assign sel_pc     = reset ? 2'd0 : ctrl.sel_pc;
  assign alu_op     = reset ? 2'd0 : ctrl.alu_op;
  assign illegal    = !reset && (illegal_decode || timeout_hit);
  assign state      = state_reg;

`ifdef MC_PERF_CNT_EN
  logic [31:0] perf_cycles_reg;
  logic [31:0] perf_instrs_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_cycles_reg <= '0;
      perf_instrs_reg <= '0;
    end else begin
      perf_cycles_reg <= perf_cycles_reg + 32'd1;
      if (state_reg == FETCH && state_next == DECODE)
        perf_instrs_reg <= perf_instrs_reg + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_reg;
  assign perf_instrs = perf_instrs_reg;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm (FETCH_TIMEOUT=4); perf counter
// checks are compiled in when MC_PERF_CNT_EN is defined.
module tb_multicycle_control_fsm;
  import mc_control_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, iord, dmem_we, ir_we, pc_we, rf_we, sel_alu_a, illegal;
  logic [1:0] sel_wa, sel_alu_b, sel_result, sel_pc, alu_op;
  logic [3:0] state;
`ifdef MC_PERF_CNT_EN
  logic [31:0] perf_cycles, perf_instrs;
`endif

  int total = 0;
  int bad   = 0;

  // {mem_req, dmem_we, ir_we, pc_we, rf_we, illegal}
  wire [5:0] strb = {mem_req, dmem_we, ir_we, pc_we, rf_we, illegal};

  multicycle_control_fsm #(.FETCH_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord),
    .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
    .sel_wa(sel_wa), .sel_alu_a(sel_alu_a), .sel_alu_b(sel_alu_b),
    .sel_result(sel_result), .sel_pc(sel_pc), .alu_op(alu_op),
    .state(state), .illegal(illegal)
`ifdef MC_PERF_CNT_EN
    , .perf_cycles(perf_cycles), .perf_instrs(perf_instrs)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic st(input string tag, input mc_state_t s, input logic [5:0] s_exp);
    chk({tag, "_state"}, 32'(state), 32'(s));
    chk({tag, "_strb"}, 32'(strb), 32'(s_exp));
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    st("rst", FETCH, 6'b000000);
    chk("rst_sel", 32'({iord, sel_wa, sel_alu_a, sel_alu_b, sel_result, sel_pc, alu_op}), 32'd0);

    // lw
    reset = 1'b0; opcode = OP_LW; #1;
    st("lw_f", FETCH, 6'b101100);
    chk("lw_f_iord", 32'(iord), 32'd0);
    chk("lw_f_alub", 32'(sel_alu_b), 32'd1);
    tick(); st("lw_d", DECODE, 6'b000000);
    chk("lw_d_alub", 32'(sel_alu_b), 32'd3);
    tick(); st("lw_ma", MEMADR, 6'b000000);
    chk("lw_ma_ab", 32'({sel_alu_a, sel_alu_b}), 32'b110);
    tick(); st("lw_rd", MEMRD, 6'b100000);
    chk("lw_rd_iord", 32'(iord), 32'd1);
    tick(); st("lw_wb", MEMWB, 6'b000010);
    chk("lw_wb_sel", 32'({sel_wa, sel_result}), 32'b0001);
    tick(); st("lw_end", FETCH, 6'b101100);

    // sw with three wait states; acked exactly at the timeout limit
    opcode = OP_SW; #1;
    tick(); st("sw_d", DECODE, 6'b000000);
    tick(); st("sw_ma", MEMADR, 6'b000000);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); st($sformatf("sw_wr%0d", i), MEMWR, 6'b110000);
    end
    tick(); mem_ready = 1'b1; #1;
    st("sw_wr3", MEMWR, 6'b110000);
    tick(); st("sw_end", FETCH, 6'b101100);

    // beq taken, then not taken
    opcode = OP_BEQ; zero = 1'b1; #1;
    tick(); st("beq1_d", DECODE, 6'b000000);
    tick(); st("beq1_br", BRANCH, 6'b000100);
    chk("beq1_sel", 32'({sel_pc, alu_op}), 32'b0101);
    tick(); st("beq1_end", FETCH, 6'b101100);
    zero = 1'b0; #1;
    tick(); tick(); st("beq0_br", BRANCH, 6'b000000);
    tick(); st("beq0_end", FETCH, 6'b101100);

    // jal
    opcode = OP_JAL; #1;
    tick(); tick(); st("jal", JAL, 6'b000110);
    chk("jal_sel", 32'({sel_wa, sel_result, sel_pc}), 32'b101010);
    tick();

    // jr
    opcode = OP_RTYPE; funct = FN_JR; #1;
    tick(); tick(); st("jr", JR, 6'b000100);
    chk("jr_pc", 32'(sel_pc), 32'd3);
    tick();

    // add
    funct = FN_ADD; #1;
    tick(); tick(); st("add_ex", RTYPE_EX, 6'b000000);
    chk("add_ex_op", 32'({sel_alu_a, sel_alu_b, alu_op}), 32'b10010);
    tick(); st("add_wb", ALU_WB, 6'b000010);
    chk("add_wb_sel", 32'({sel_wa, sel_result}), 32'b0100);
    tick();

    // unsupported opcode
    opcode = 6'h3F; #1;
    tick(); st("ill_d", DECODE, 6'b000001);
    tick(); st("ill_end", FETCH, 6'b101100);

    // reset in the middle of a stalled MEMRD
    opcode = OP_LW; #1;
    tick(); tick(); mem_ready = 1'b0; #1;
    tick(); st("rrd", MEMRD, 6'b100000);
    reset = 1'b1; #1;
    chk("rrd_rst_strb", 32'(strb), 32'd0);
    tick(); reset = 1'b0; #1;

    // mem_ready stuck low in FETCH: timeout on the 4th cycle
    st("to_1", FETCH, 6'b100000);
    tick(); st("to_2", FETCH, 6'b100000);
    tick(); st("to_3", FETCH, 6'b100000);
    tick(); st("to_4", FETCH, 6'b000001);
    tick(); st("to_after", FETCH, 6'b100000);

`ifdef MC_PERF_CNT_EN
    reset = 1'b1; mem_ready = 1'b1; #1;
    tick();
    chk("perf_rst", perf_cycles | perf_instrs, 32'd0);
    reset = 1'b0; opcode = OP_BEQ; zero = 1'b0; #1;
    repeat (9) tick();
    chk("perf_instrs", perf_instrs, 32'd3);
    chk("perf_cycles", perf_cycles, 32'd9);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
